// File: rtl/fifo_pkg.sv
// ============================================================
// fifo_pkg : shared defaults and widths for the byte FIFO
// Rev 1.0
// ============================================================
`default_nettype none

package fifo_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 8;
  localparam int PTR_W      = $clog2(DEPTH);
  localparam int CNT_W      = 8;
endpackage

`default_nettype wire

// File: rtl/fifo_mem.sv
// ============================================================
// fifo_mem : register array, one write port, registered read port
// Rev 1.0
// ============================================================
`default_nettype none

module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately left unreset so it can map onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

`default_nettype wire

// File: rtl/fifo.sv
// ============================================================
// fifo : single-clock synchronous FIFO with occupancy counter
// Rev 1.0
// ============================================================
`default_nettype none

module fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int DEPTH      = fifo_pkg::DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] buf_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] buf_out,
  output logic                  buf_empty,
  output logic                  buf_full,
  output logic [CNT_W-1:0]      fifo_counter
);

  localparam int P_W = $clog2(DEPTH);

  logic [P_W-1:0] wr_ptr;
  logic [P_W-1:0] rd_ptr;
  logic           wr_ok;
  logic           rd_ok;

  assign buf_empty = (fifo_counter == '0);
  assign buf_full  = (fifo_counter == CNT_W'(DEPTH));

  // Qualifying with the flags drops overflowing writes and underflowing reads.
  assign wr_ok = wr_en && !buf_full;
  assign rd_ok = rd_en && !buf_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_counter <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + P_W'(1);
      if (rd_ok) rd_ptr <= rd_ptr + P_W'(1);
      case ({wr_ok, rd_ok})
        2'b10:   fifo_counter <= fifo_counter + CNT_W'(1);
        2'b01:   fifo_counter <= fifo_counter - CNT_W'(1);
        default: fifo_counter <= fifo_counter;
      endcase
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (P_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (buf_in),
    .re    (rd_ok),
    .raddr (rd_ptr),
    .rdata (buf_out)
  );

endmodule

`default_nettype wire

// File: tb/tb_fifo.sv
// ============================================================
// tb_fifo : table-driven directed bench for fifo
// Rev 1.0
// ============================================================
`default_nettype none

module tb_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] buf_in;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] buf_out;
  logic       buf_empty;
  logic       buf_full;
  logic [7:0] fifo_counter;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [7:0] cnt;
    logic       emp;
    logic       ful;
    logic [7:0] out;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  fifo dut (
    .clk          (clk),
    .rst          (rst),
    .buf_in       (buf_in),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .buf_out      (buf_out),
    .buf_empty    (buf_empty),
    .buf_full     (buf_full),
    .fifo_counter (fifo_counter)
  );

  function automatic void add(input logic wr, input logic rd, input int din,
                              input int cnt, input logic emp, input logic ful,
                              input int out);
    vec_t v;
    v.wr  = wr;
    v.rd  = rd;
    v.din = 8'(din);
    v.cnt = 8'(cnt);
    v.emp = emp;
    v.ful = ful;
    v.out = 8'(out);
    vecs.push_back(v);
  endfunction

  task automatic check(input string tag, input logic [7:0] cnt, input logic emp,
                       input logic ful, input logic [7:0] out);
    checks++;
    if (fifo_counter !== cnt || buf_empty !== emp || buf_full !== ful || buf_out !== out) begin
      errors++;
      $display("FAIL %s: got cnt=%0d empty=%b full=%b out=%0d, expected cnt=%0d empty=%b full=%b out=%0d",
               tag, fifo_counter, buf_empty, buf_full, buf_out, cnt, emp, ful, out);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    wr_en  = v.wr;
    rd_en  = v.rd;
    buf_in = v.din;
    @(posedge clk);
    #1;
    check(tag, v.cnt, v.emp, v.ful, v.out);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // basic write then read
    add(1, 0, 10, 1, 0, 0, 0);
    add(1, 0, 20, 2, 0, 0, 0);
    add(1, 0, 30, 3, 0, 0, 0);
    add(1, 0, 40, 4, 0, 0, 0);
    add(0, 1, 0, 3, 0, 0, 10);
    add(0, 1, 0, 2, 0, 0, 20);
    add(0, 1, 0, 1, 0, 0, 30);
    add(0, 1, 0, 0, 1, 0, 40);
    // fill, overflow attempt, drain
    for (int i = 1; i <= 8; i++) add(1, 0, i, i, 0, i == 8, 40);
    add(1, 0, 99, 8, 0, 1, 40);
    for (int i = 1; i <= 8; i++) add(0, 1, 0, 8 - i, i == 8, 0, i);
    // underflow: buf_out holds
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 1, 0, 8);
    // simultaneous from empty
    add(1, 1, 50, 1, 0, 0, 8);
    add(1, 1, 60, 1, 0, 0, 50);
    add(1, 1, 70, 1, 0, 0, 60);
    add(0, 1, 0, 0, 1, 0, 70);
    // simultaneous from full: write of 200 dropped
    for (int i = 1; i <= 8; i++) add(1, 0, 100 + i, i, 0, i == 8, 70);
    add(1, 1, 200, 7, 0, 0, 101);
    for (int i = 2; i <= 8; i++) add(0, 1, 0, 8 - i, i == 8, 0, 100 + i);

    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; buf_in = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", 8'd0, 1'b1, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", 8'd0, 1'b1, 1'b0, 8'd0);

    foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

    // asynchronous reset in mid-operation, checked before any clock edge
    vecs.delete();
    add(1, 0, 5, 1, 0, 0, 108);
    add(1, 0, 6, 2, 0, 0, 108);
    foreach (vecs[i]) step(vecs[i], $sformatf("pre_rst%0d", i));
    @(negedge clk);
    wr_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", 8'd0, 1'b1, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b1;

    // wrap-around after reset
    vecs.delete();
    for (int i = 1; i <= 7; i++) add(1, 0, i, i, 0, 0, 0);
    for (int i = 1; i <= 7; i++) add(0, 1, 0, 7 - i, i == 7, 0, i);
    for (int i = 1; i <= 4; i++) add(1, 0, 10 + i, i, 0, 0, 7);
    for (int i = 1; i <= 4; i++) add(0, 1, 0, 4 - i, i == 4, 0, 10 + i);
    foreach (vecs[i]) step(vecs[i], $sformatf("wrap%0d", i));

    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
